weight_row_loader: RTL and testbench

//  Streams an N x N weight matrix out of the weight BRAM (read-only use of its

---
 rtl/weight_row_loader.sv | 123 ++++++++++++
 tb/tb_weight_row_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_row_loader.sv
// Weight row loader: reads an N x N row-major weight matrix out of a BRAM
// read port and hands it to the systolic array one packed row at a time
// over a valid/ready handshake.
module weight_row_loader #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      bram_address,
  output logic                   bram_chipselect,
  output logic                   bram_clken,
  output logic                   bram_write,
  input  logic [31:0]            bram_readdata,
  output logic [N*DATA_W-1:0]    row_data,
  output logic                   row_valid,
  input  logic                   row_ready,
  output logic [$clog2(N)-1:0]   row_index,
  output logic                   last_row
);

  localparam int IDX_W = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_OUT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q;
  logic [IDX_W-1:0]    row_q;
  logic [IDX_W-1:0]    col_q;
  logic [N*DATA_W-1:0] row_data_q;
  logic                last_col;
  logic                is_last_row;
  logic                unused_upper;

  assign last_col    = (col_q == IDX_W'(N-1));
  assign is_last_row = (row_q == IDX_W'(N-1));

  // Only the low DATA_W bits of each BRAM word carry a weight.
  assign unused_upper = ^bram_readdata[31:DATA_W];

  // Next-state logic for the load sequence.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start)     state_d = S_READ;
      S_READ: if (last_col)  state_d = S_CAPT;
      S_CAPT:                state_d = S_OUT;
      S_OUT:  if (row_ready) state_d = is_last_row ? S_DONE : S_READ;
      S_DONE:                state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any load in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Base latch, row/column counters and row assembly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      // NOTE: the row buffer is reset so a partial row never leaks out after an abort.
      row_data_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q <= base_addr;
            row_q  <= '0;
            col_q  <= '0;
          end
        end
        S_READ: begin
          col_q <= last_col ? '0 : col_q + 1'b1;
          // Read data lags the address by one cycle, so column k-1 lands now.
          if (col_q != '0)
            row_data_q[(32'(col_q) - 32'd1)*DATA_W +: DATA_W] <= bram_readdata[DATA_W-1:0];
        end
        S_CAPT: begin
          row_data_q[(N-1)*DATA_W +: DATA_W] <= bram_readdata[DATA_W-1:0];
        end
        S_OUT: begin
          if (row_ready && !is_last_row) row_q <= row_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Element address (base + r*N + c) wraps modulo the BRAM depth.
  assign bram_address    = (state_q == S_READ)
                         ? ADDR_W'((32'(base_q) + 32'(row_q) * 32'(N) + 32'(col_q)) % 32'(DEPTH))
                         : '0;
  assign bram_chipselect = (state_q == S_READ);
  assign bram_clken      = 1'b1;
  assign bram_write      = 1'b0;

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign row_valid = (state_q == S_OUT);
  assign last_row  = (state_q == S_OUT) && is_last_row;
  assign row_data  = row_data_q;
  assign row_index = row_q;

endmodule

// File: tb/tb_weight_row_loader.sv
// Scoreboarded bench for weight_row_loader: the stimulus pushes the rows a
// load should produce (computed straight from the row-major memory layout),
// and a negedge monitor pops and compares every accepted row.
module tb_weight_row_loader;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int IW    = $clog2(N);

  typedef struct {
    logic [N*DW-1:0] data;
    logic [IW-1:0]   idx;
    logic            last;
  } row_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic            busy, done;
  logic [AW-1:0]   bram_address;
  logic            bram_chipselect, bram_clken, bram_write;
  logic [31:0]     bram_readdata;
  logic [N*DW-1:0] row_data;
  logic            row_valid;
  logic            row_ready;
  logic [IW-1:0]   row_index;
  logic            last_row;

  logic [31:0] mem [DEPTH];
  row_t        exp_q[$];
  row_t        e;
  int          n_vec = 0;
  int          n_err = 0;
  int          done_count = 0;
  int          ready_mode = 0;   // 0: held high, 1: random, 2: ready_force
  logic        ready_force = 1'b1;
  logic        prev_stall = 1'b0;
  logic [N*DW-1:0] prev_data;

  weight_row_loader #(.N(N), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .bram_address(bram_address),
    .bram_chipselect(bram_chipselect), .bram_clken(bram_clken),
    .bram_write(bram_write), .bram_readdata(bram_readdata),
    .row_data(row_data), .row_valid(row_valid), .row_ready(row_ready),
    .row_index(row_index), .last_row(last_row)
  );

  always #5 clk = ~clk;

  // BRAM read port: registered, data one cycle after the address.
  always @(posedge clk) bram_readdata <= mem[bram_address];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference: element (r,c) lives at (base + r*N + c) mod DEPTH, low byte only.
  function automatic logic [N*DW-1:0] model_row(input int base, input int r);
    logic [N*DW-1:0] v;
    logic [31:0]     w;
    for (int c = 0; c < N; c++) begin
      w = mem[(base + r*N + c) % DEPTH];
      v[c*DW +: DW] = w[DW-1:0];
    end
    return v;
  endfunction

  // row_ready driver, updated a few ns after each edge.
  initial begin
    row_ready = 1'b1;
    forever begin
      @(posedge clk);
      #3;
      case (ready_mode)
        0:       row_ready = 1'b1;
        1:       row_ready = 1'($urandom_range(0, 1));
        default: row_ready = ready_force;
      endcase
    end
  end

  // Monitor: compares accepted rows and checks stability while stalled.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (done) done_count++;
      if (prev_stall) begin
        check("stall_valid_held", row_valid, 1'b1);
        check("stall_data_held", row_data, prev_data);
        check("stall_no_read", bram_chipselect, 1'b0);
      end
      if (row_valid && row_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_row: got row_index %0d data %0h, required no row", row_index, row_data);
        end else begin
          e = exp_q.pop_front();
          check("row_data", row_data, e.data);
          check("row_index", row_index, e.idx);
          check("last_row", last_row, e.last);
          check("bram_write_low", bram_write, 1'b0);
          check("bram_clken_high", bram_clken, 1'b1);
        end
      end
      prev_stall = row_valid && !row_ready;
      prev_data  = row_data;
    end
  end

  // Pulse start (caller is just after a posedge) and push the expected rows.
  task automatic issue_start(input logic [AW-1:0] b);
    start     = 1'b1;
    base_addr = b;
    for (int r = 0; r < N; r++)
      exp_q.push_back('{data: model_row(int'(b), r), idx: IW'(r), last: (r == N-1)});
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_rise", busy, 1'b1);
  endtask

  task automatic wait_row(input int r);
    int cnt = 0;
    while (!(row_valid && row_index == IW'(r)) && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    if (cnt >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_row_timeout: got no row %0d in %0d cycles, required one", r, cnt);
    end
  endtask

  // Waits for done; with check_lat, verifies latencies for a ready-high load.
  // A full load spans N*(N+2)+2 cycles counting the start and done cycles.
  task automatic wait_done(input bit check_lat);
    int cnt   = 0;
    int first = -1;
    while (!done && cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
      if (row_valid && first < 0) first = cnt;
    end
    if (cnt >= 400) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done in %0d cycles, required one", cnt);
    end else begin
      if (check_lat) begin
        check("first_valid_latency", 64'(first), 64'(N + 1));
        check("done_latency", 64'(cnt), 64'(N*(N+2) + 2 - 2));
      end
      check("busy_during_done", busy, 1'b1);
      check("rows_all_delivered", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
      check("busy_fall_done_clear", {busy, done}, 2'b00);
    end
  endtask

  task automatic fill_address_pattern();
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);
  endtask

  initial begin
    int dc;
    logic [31:0] w;
    reset_n   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    fill_address_pattern();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state",
          {busy, done, row_valid, last_row, bram_chipselect, row_index, bram_address, row_data}, '0);
    check("reset_ports_tied", {bram_clken, bram_write}, 2'b10);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: base 0, address pattern, ready high; latency checks.
    issue_start(4'd0);
    wait_done(1'b1);

    // 2: wrap-around from base 14.
    issue_start(4'd14);
    wait_done(1'b0);

    // 3: stall row 1 for five cycles.
    ready_mode  = 2;
    ready_force = 1'b1;
    issue_start(4'd0);
    wait_row(1);
    ready_force = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_row1_data", row_data, 32'h07060504);
      check("stall_row1_valid_noread", {row_valid, bram_chipselect}, 2'b10);
    end
    ready_force = 1'b1;
    wait_done(1'b0);
    ready_mode = 0;

    // 4: start pulsed during the READ of row 2 is ignored.
    dc = done_count;
    issue_start(4'd0);
    wait_row(1);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = 4'd9;
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = 4'd0;
    wait_done(1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("single_done_pulse", 64'(done_count - dc), 64'd1);

    // 5: reset during OUT of row 1.
    dc = done_count;
    issue_start(4'd3);
    wait_row(1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_clear",
          {busy, done, row_valid, last_row, bram_chipselect, row_index, bram_address, row_data}, '0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_done_after_abort", 64'(done_count - dc), 64'd0);
    issue_start(4'd5);
    wait_done(1'b1);

    // 6: upper word bits set must be ignored.
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      mem[i] = {24'hDEADBE, w[7:0]};
    end
    mem[0] = 32'hDEADBE80;
    issue_start(4'd0);
    wait_done(1'b0);

    // Randomized loads with random memory, base and ready back-pressure.
    ready_mode = 1;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      issue_start(AW'($urandom_range(0, DEPTH-1)));
      wait_done(1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    ready_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test by 500000 ns, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
